pwm_wrapper: RTL and testbench
==============================

// Module: pwm_wrapper
// PURPOSE
//  Motor-drive PWM generator. Turns a 16-bit sign-magnitude speed command into a
//  fixed-frequency PWM speed output (spd) and a direction level (dir) for an
//  H-bridge driver. Sits between the control/command logic and the board pins.
//  Duty and direction update only on PWM period boundaries, so output pulses never glitch.
// PARAMETERS
//  CNT_W        12  PWM counter width; period = 2**CNT_W clocks (4096 -> 24.4 kHz @100 MHz)
//  DEAD_PERIODS 1   full PWM periods with spd forced low before dir is allowed to change
// PORTS
//  CLK100MHZ  in   1   system clock, 100 MHz; the only clock
//  rst        in   1   reset, asynchronous, active-low (rst==0 resets)
//  data_in    in   16  speed command, synchronous to CLK100MHZ; [15]=dir request (1=reverse),
//                      [14:0]=unsigned magnitude
//  spd        out  1   PWM speed output, registered
//  dir        out  1   direction output, registered, 0=forward
// BEHAVIOUR
//  Reset (rst==0, async): cnt=0, duty_q=0, dir=0, spd=0, state=RUN, dead_cnt=0.
//  Counter: cnt increments every clock and wraps from 2**CNT_W-1 to 0.
//   Boundary = the edge where cnt wraps to 0.
//  Duty mapping: duty_new = data_in[14:(15-CNT_W)] (top CNT_W magnitude bits; truncated).
//   0x7FFF -> 4095/4096 high. Magnitude < 2**(15-CNT_W) -> duty 0.
//   100% duty is unreachable; this is required.
//  spd: registered, spd <= (cnt_next < duty_next) && (state_next==RUN).
//   The high phase starts on the boundary edge. duty 0 -> spd constant 0.
//  data_in sampling: sampled only at boundaries. Changes mid-period have no effect
//   until the next boundary.
//  State machine, evaluated only at boundaries:
//   RUN:
//     - data_in[15]==dir: duty_q <= duty_new; stay in RUN.
//     - data_in[15]!=dir: duty_q <= 0; dead_cnt <= DEAD_PERIODS-1; go to DEAD.
//       dir is unchanged.
//   DEAD: spd held 0 for the whole period.
//     - dead_cnt!=0: decrement dead_cnt; stay in DEAD.
//     - dead_cnt==0: dir <= data_in[15] (re-sampled now); duty_q <= duty_new; go to RUN.
//       If the request has reverted, dir is unchanged and the block simply resumes.
//  Latency: a command applied during period N drives spd from the first edge of period N+1.
//   A direction change takes effect after DEAD_PERIODS+1 boundaries.
//  Async reset mid-period: spd and dir drop to 0 immediately. After release, the counter
//   restarts at 0 with duty 0, so the first full period is all low.
//  Simultaneous events: the boundary update and the data_in change in the same cycle
//   use the data_in value present at that edge.
// STRUCTURE
//  pwm_pkg: CNT_W default, DEAD_PERIODS default, state typedef enum {RUN, DEAD},
//   DIR_FWD/DIR_REV constants.
//  One sub-module, pwm_core: free-running counter + compare -> raw pwm, exports boundary pulse.
//   pwm_wrapper holds the sampling, state machine, dir register and output registers.
// TESTING (CLK100MHZ 10 ns period, CNT_W=12, DEAD_PERIODS=1)
//  1. Hold rst=0 for 3 clk with data_in=0x4000 -> spd=0, dir=0. Release rst ->
//     spd stays 0 for the first 4096 clk, then goes high.
//  2. data_in=0x4000 steady -> each period spd high exactly 2048 clk then low 2048 clk; dir=0.
//  3. data_in=0x7FFF -> spd high 4095 clk, low 1 clk per period.
//     data_in=0x0007 -> spd never high.
//  4. Running 0x4000, apply 0xC000 -> next period spd low for all 4096 clk, dir still 0.
//     At the following boundary dir=1 and spd resumes at 50% duty.
//  5. Change data_in from 0x4000 to 0x2000 at cnt=100 -> current period keeps 2048 high.
//     The next period has 1024 high.
//  6. Assert rst=0 at cnt=1000 with spd=1, dir=1 -> spd=0, dir=0 within the same timestep,
//     without waiting for a clock edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// ============================================================================
// pwm_pkg : shared defaults, FSM state type and direction encodings for the
//           motor-drive PWM block.                                    rev 1.0
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int unsigned CNT_W_DEF        = 12;
  localparam int unsigned DEAD_PERIODS_DEF = 1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pwm_core.sv
// ============================================================================
// pwm_core : free-running period counter with duty compare; flags the cycle
//            whose closing edge wraps the counter to zero.            rev 1.0
// ============================================================================
`default_nettype none

module pwm_core
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CNT_W-1:0] duty_i,
  output logic             wrap_o,
  output logic             raw_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare against the next count so the registered output lines up with it.
  assign wrap_o = &cnt_q;
  assign raw_o  = (cnt_d < duty_i);

endmodule

`default_nettype wire

// File: rtl/pwm_wrapper.sv
// ============================================================================
// pwm_wrapper : sign-magnitude speed command to glitch-free PWM + direction,
//               with dead periods around every direction reversal.    rev 1.0
// ============================================================================
`default_nettype none

module pwm_wrapper
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEAD_PERIODS = DEAD_PERIODS_DEF
) (
  input  logic        CLK100MHZ,
  input  logic        rst,
  input  logic [15:0] data_in,
  output logic        spd,
  output logic        dir
);

  localparam int unsigned DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [DEAD_W-1:0] DEAD_RELOAD = DEAD_W'(DEAD_PERIODS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    duty_q, duty_d;
  logic                dir_q, dir_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic                spd_q, spd_d;

  logic                wrap;
  logic                raw;
  logic [CNT_W-1:0]    duty_new;
  logic                req_dir;
  logic                unused_data;

  // Truncation drops the low magnitude bits; full-scale therefore stops one count short of 100%.
  assign duty_new    = data_in[14 -: CNT_W];
  assign req_dir     = data_in[15];
  assign unused_data = ^data_in;

  pwm_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i  (CLK100MHZ),
    .rst_ni (rst),
    .duty_i (duty_d),
    .wrap_o (wrap),
    .raw_o  (raw)
  );

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    if (wrap) begin
      unique case (state_q)
        ST_RUN: begin
          if (req_dir == dir_q) begin
            duty_d = duty_new;
          end else begin
            duty_d  = '0;
            dead_d  = DEAD_RELOAD;
            state_d = ST_DEAD;
          end
        end
        ST_DEAD: begin
          if (dead_q != '0) begin
            dead_d = dead_q - DEAD_W'(1);
          end else begin
            // Re-sample here: a request that reverted during the dead time just resumes.
            dir_d   = req_dir;
            duty_d  = duty_new;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
    spd_d = raw && (state_d == ST_RUN);
  end

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      duty_q  <= '0;
      dir_q   <= DIR_FWD;
      dead_q  <= '0;
      spd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      spd_q   <= spd_d;
    end
  end

  assign spd = spd_q;
  assign dir = dir_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_wrapper.sv
// ============================================================================
// tb_pwm_wrapper : directed self-checking bench for pwm_wrapper.      rev 1.0
// ============================================================================
`default_nettype none

module tb_pwm_wrapper;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        spd;
  logic        dir;

  int errors = 0;
  int checks = 0;

  // Reference period counter: restarts with reset, wraps every 4096 clocks.
  logic [11:0] tcnt;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) tcnt <= '0;
    else      tcnt <= tcnt + 12'd1;
  end

  pwm_wrapper #(
    .CNT_W        (12),
    .DEAD_PERIODS (1)
  ) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .data_in   (data_in),
    .spd       (spd),
    .dir       (dir)
  );

  task automatic wait_cnt(input logic [11:0] target);
    int n;
    n = 0;
    while (tcnt !== target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (tcnt !== target) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt: counter=%0d required=%0d", tcnt, target);
    end
  endtask

  task automatic next_period();
    @(negedge clk);
    wait_cnt(12'd0);
  endtask

  // Samples one full period starting at count 0; optionally changes data_in mid-period.
  task automatic measure(input int chg_at, input logic [15:0] chg_val,
                         output int highs, output int first_low);
    highs     = 0;
    first_low = 4096;
    for (int i = 0; i < 4096; i++) begin
      if (i == chg_at) data_in = chg_val;
      if (spd === 1'b1) highs++;
      else if (first_low == 4096) first_low = i;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int h, fl;
    rst     = 1'b0;
    data_in = 16'h4000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (spd !== 1'b0) begin
      errors++;
      $display("FAIL reset_spd: got=%b exp=0", spd);
    end
    checks++;
    if (dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_dir: got=%b exp=0", dir);
    end
    rst = 1'b1;
    wait_cnt(12'd0);
    measure(-1, 16'h0000, h, fl);
    checks++;
    if (h !== 0) begin
      errors++;
      $display("FAIL reset_first_period: high=%0d exp=0", h);
    end
  endtask

  task automatic test_half_duty();
    int h, fl;
    for (int p = 0; p < 2; p++) begin
      measure(-1, 16'h0000, h, fl);
      checks++;
      if (h !== 2048 || fl !== 2048) begin
        errors++;
        $display("FAIL half_duty[%0d]: high=%0d first_low=%0d exp=2048/2048", p, h, fl);
      end
    end
    checks++;
    if (dir !== 1'b0) begin
      errors++;
      $display("FAIL half_duty_dir: got=%b exp=0", dir);
    end
  endtask

  task automatic test_extremes();
    int h, fl;
    data_in = 16'h7FFF;
    next_period();
    measure(-1, 16'h0000, h, fl);
    checks++;
    if (h !== 4095 || fl !== 4095) begin
      errors++;
      $display("FAIL full_scale: high=%0d first_low=%0d exp=4095/4095", h, fl);
    end
    data_in = 16'h0007;
    next_period();
    measure(-1, 16'h0000, h, fl);
    checks++;
    if (h !== 0) begin
      errors++;
      $display("FAIL below_lsb: high=%0d exp=0", h);
    end
    data_in = 16'h0008;
    next_period();
    measure(-1, 16'h0000, h, fl);
    checks++;
    if (h !== 1 || fl !== 1) begin
      errors++;
      $display("FAIL one_lsb: high=%0d first_low=%0d exp=1/1", h, fl);
    end
  endtask

  task automatic test_dir_change();
    int h, fl;
    data_in = 16'h4000;
    next_period();
    measure(-1, 16'h0000, h, fl);
    checks++;
    if (h !== 2048) begin
      errors++;
      $display("FAIL dir_pre: high=%0d exp=2048", h);
    end
    data_in = 16'hC000;
    next_period();
    checks++;
    if (dir !== 1'b0) begin
      errors++;
      $display("FAIL dead_dir: got=%b exp=0", dir);
    end
    measure(-1, 16'h0000, h, fl);
    checks++;
    if (h !== 0) begin
      errors++;
      $display("FAIL dead_period: high=%0d exp=0", h);
    end
    checks++;
    if (dir !== 1'b1) begin
      errors++;
      $display("FAIL dir_switched: got=%b exp=1", dir);
    end
    measure(-1, 16'h0000, h, fl);
    checks++;
    if (h !== 2048 || fl !== 2048) begin
      errors++;
      $display("FAIL dir_resume: high=%0d first_low=%0d exp=2048/2048", h, fl);
    end
  endtask

  task automatic test_mid_change();
    int h, fl;
    measure(100, 16'hA000, h, fl);
    checks++;
    if (h !== 2048 || fl !== 2048) begin
      errors++;
      $display("FAIL mid_change_hold: high=%0d first_low=%0d exp=2048/2048", h, fl);
    end
    measure(-1, 16'h0000, h, fl);
    checks++;
    if (h !== 1024 || fl !== 1024) begin
      errors++;
      $display("FAIL mid_change_next: high=%0d first_low=%0d exp=1024/1024", h, fl);
    end
    checks++;
    if (dir !== 1'b1) begin
      errors++;
      $display("FAIL mid_change_dir: got=%b exp=1", dir);
    end
  endtask

  task automatic test_async_reset();
    int h, fl;
    wait_cnt(12'd1000);
    checks++;
    if (spd !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: spd=%b dir=%b exp=1/1", spd, dir);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (spd !== 1'b0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: spd=%b dir=%b exp=0/0", spd, dir);
    end
    data_in = 16'h2000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_cnt(12'd0);
    measure(-1, 16'h0000, h, fl);
    checks++;
    if (h !== 0) begin
      errors++;
      $display("FAIL post_reset_first: high=%0d exp=0", h);
    end
    measure(-1, 16'h0000, h, fl);
    checks++;
    if (h !== 1024 || fl !== 1024) begin
      errors++;
      $display("FAIL post_reset_second: high=%0d first_low=%0d exp=1024/1024", h, fl);
    end
  endtask

  initial begin
    test_reset();
    test_half_duty();
    test_extremes();
    test_dir_change();
    test_mid_change();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
